// File: rtl/cnt_param.sv
// cnt_param: parameterised up/down counter with load, saturate-or-wrap terminal behaviour,
// a cascade carry, a one-cycle wrap pulse and a sticky overflow flag.
//
// Optional feature: define CNT_PRESCALE_EN to insert an enable prescaler so that only every
// PRESCALE-th en-high cycle produces a step. Without the macro every en-high cycle is a step.
//
// Parameters:
//   WIDTH     counter width in bits (1..32)
//   MAX       terminal count, 1..2**WIDTH-1
//   PRESCALE  enable-divide ratio (>=1), only meaningful with CNT_PRESCALE_EN
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   en        count enable
//   load      synchronous load strobe (beats a step)
//   load_val  load value, clamped to MAX
//   up        direction, 1 = up, 0 = down
//   sat       terminal mode, 1 = saturate, 0 = wrap
//   clr_ovf   clears the sticky overflow flag (a same-edge set wins)
//   cnt       registered count value
//   tc        combinational terminal-count / carry for cascading
//   wrap      registered one-cycle pulse after a wrapping terminal step
//   ovf       registered sticky overflow flag
module cnt_param #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZeroVal = '0;

  logic tick;      // prescaler permits a step on this edge
  logic step;      // this edge advances the counter
  logic terminal;  // counter sits at the end it is moving towards

`ifdef CNT_PRESCALE_EN
  localparam int unsigned     PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0]  PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_cnt;

  // The tick coincides with the PRESCALE-th en-high cycle of the current interval.
  assign tick = (ps_cnt == PsLast);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ps_cnt <= '0;
    end else if (load) begin
      ps_cnt <= '0;
    end else if (en) begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick            = 1'b1;
`endif

  assign step     = en & ~load & tick;
  assign terminal = up ? (cnt == MaxVal) : (cnt == ZeroVal);

  // Gated by rst so a cascaded stage never sees a carry while this one is in reset.
  assign tc = rst & step & terminal;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      // Clear first so a same-edge terminal step below overrides it.
      if (clr_ovf) begin
        ovf <= 1'b0;
      end
      if (load) begin
        cnt <= (load_val > MaxVal) ? MaxVal : load_val;
      end else if (step) begin
        if (terminal) begin
          ovf <= 1'b1;
          if (!sat) begin
            cnt  <= up ? ZeroVal : MaxVal;
            wrap <= 1'b1;
          end
        end else begin
          cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
        end
      end
    end
  end

endmodule
